mem_port_arbiter: RTL

- Shares the core's single-port unified memory between the IF-stage instruction fetch port and the MEM-stage load/store port.
- Serialises accesses with one transaction outstanding at a time.
- Counts the fixed memory latency and returns read data and write acks to the winning requester.
- Data port has priority, backed by a starvation guard for fetch. Sits between the pipeline stages and the memory array; its stall signals feed hazard/stall logic.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_prio_sel.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // The latency counter is 4 bits wide, so MEM_LAT is bounded to 1..15.
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;

    function automatic bit mem_lat_ok(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_prio_sel.sv
// Winner select for the arbiter: data first, fetch once it has lost STARVE_MAX times in a row.
module arb_prio_sel
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic arb_en,
    input  logic gnt,
    input  logic gnt_own,
    output logic winner
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == CW'(STARVE_MAX));

    always_comb begin
        winner = OWN_D;
        if (i_req && (!d_req || starved))
            winner = OWN_I;
    end

    // Only counts while data actually beats a pending fetch, so it saturates at STARVE_MAX.
    always_ff @(posedge clk) begin
        if (!reset)
            starve_cnt <= '0;
        else if (gnt && gnt_own == OWN_I)
            starve_cnt <= '0;
        else if (arb_en && i_req && d_req && !starved)
            starve_cnt <= starve_cnt + 1'b1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and load/store, one transaction in flight.
// Optional performance counters are built when MEMARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
`ifdef MEMARB_PERF_EN
    ,
    output logic [31:0]     perf_i_grants,
    output logic [31:0]     perf_d_grants,
    output logic [31:0]     perf_conflicts
`endif
);

    if (!mem_lat_ok(MEM_LAT) || STARVE_MAX < 1) begin : g_bad_cfg
        $error("mem_port_arbiter: MEM_LAT must be 1..15 and STARVE_MAX >= 1");
    end

    state_t     state, state_n;
    logic       owner;
    logic       winner;
    logic [3:0] lat_cnt;

    arb_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .d_req   (d_req),
        .arb_en  (state == IDLE),
        .gnt     (i_gnt | d_gnt),
        .gnt_own (owner),
        .winner  (winner)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (i_req || d_req) state_n = ACCESS;
            ACCESS:  state_n = mem_we ? RESP : WAIT;
            WAIT:    if (lat_cnt == '0) state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    // The mem_* registers double as the latched request attributes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner     <= OWN_I;
            lat_cnt   <= '0;
            i_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            busy      <= 1'b0;
        end else begin
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            mem_req  <= 1'b0;
            busy     <= (state_n != IDLE);
            case (state)
                IDLE: if (i_req || d_req) begin
                    owner   <= winner;
                    mem_req <= 1'b1;
                    if (winner == OWN_D) begin
                        d_gnt     <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                    end else begin
                        i_gnt     <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                    end
                end
                ACCESS: begin
                    if (mem_we) begin
                        d_rvalid <= 1'b1;
                        d_rdata  <= '0;
                    end else begin
                        lat_cnt <= 4'(MEM_LAT - 1);
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (owner == OWN_I) begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end else begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEMARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_i_grants  <= '0;
            perf_d_grants  <= '0;
            perf_conflicts <= '0;
        end else begin
            if (i_gnt) perf_i_grants <= perf_i_grants + 1'b1;
            if (d_gnt) perf_d_grants <= perf_d_grants + 1'b1;
            if (state == IDLE && i_req && d_req) perf_conflicts <= perf_conflicts + 1'b1;
        end
    end
`endif

endmodule
